// File: rtl/wide_operand_register_pkg.sv
// Shared types and constants for the wide operand (B) register.
// Optional feature macro used across these files: B_REG_SHIFT_EN.
package wide_operand_register_pkg;

    typedef enum logic {
        B_ST_IDLE  = 1'b0,
        B_ST_ACCUM = 1'b1
    } b_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Beat counter needs at least one bit even when BEATS == 1.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/wide_operand_register_if.sv
// Bus-side interface of the wide operand register: W-bus beats in, committed operand out.
// Shift controls exist only when B_REG_SHIFT_EN is defined.
interface wide_operand_register_if #(
    parameter int BUS_WIDTH = 8,
    parameter int BEATS     = 2
);
    localparam int WIDTH = BUS_WIDTH * BEATS;

    logic [BUS_WIDTH-1:0] bus_input;
    logic                 L_B_bar;
    logic [WIDTH-1:0]     add_sub_output;
    logic                 busy;
    logic                 done;
`ifdef B_REG_SHIFT_EN
    logic                 S_B;
    logic                 DIR;
    logic                 serial_in;

    modport master (
        output bus_input, L_B_bar, S_B, DIR, serial_in,
        input  add_sub_output, busy, done
    );
    modport slave (
        input  bus_input, L_B_bar, S_B, DIR, serial_in,
        output add_sub_output, busy, done
    );
`else
    modport master (
        output bus_input, L_B_bar,
        input  add_sub_output, busy, done
    );
    modport slave (
        input  bus_input, L_B_bar,
        output add_sub_output, busy, done
    );
`endif

endinterface

// File: rtl/wide_operand_register_beat_sequencer.sv
// Beat sequencer: tracks which beat of the operand is being loaded, flags the
// final beat, and produces the busy level and the one-cycle done pulse.
module wide_operand_register_beat_sequencer
    import wide_operand_register_pkg::*;
#(
    parameter  int BEATS = 2,
    localparam int CNT_W = cnt_width(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    output logic [CNT_W-1:0] beat_idx,
    output logic             last_beat,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    b_state_t         state;
    logic [CNT_W-1:0] beat_cnt;

    assign beat_idx  = beat_cnt;
    assign last_beat = load && (beat_cnt == LAST_IDX);
    // State alone drives busy, so it cannot glitch while the commit edge resolves.
    assign busy      = (state == B_ST_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= B_ST_IDLE;
            beat_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= last_beat;
            if (load) begin
                if (beat_cnt == LAST_IDX) begin
                    beat_cnt <= '0;
                    state    <= B_ST_IDLE;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    state    <= B_ST_ACCUM;
                end
            end
        end
    end

endmodule

// File: rtl/wide_operand_register.sv
// Wide operand (B) register: assembles BEATS narrow W-bus beats in a shadow and
// commits the full operand atomically. Optional shift enabled by B_REG_SHIFT_EN.
module wide_operand_register
    import wide_operand_register_pkg::*;
#(
    parameter  int BUS_WIDTH = 8,
    parameter  int BEATS     = 2,
    localparam int WIDTH     = BUS_WIDTH * BEATS,
    localparam int CNT_W     = cnt_width(BEATS)
) (
    input  logic                    CLK,
    input  logic                    CLR_bar,
    wide_operand_register_if.slave  bus
);

    logic             load;
    logic [CNT_W-1:0] beat_idx;
    logic             last_beat;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] operand;

    assign load = ~bus.L_B_bar;

    wide_operand_register_beat_sequencer #(
        .BEATS (BEATS)
    ) u_seq (
        .clk       (CLK),
        .rst_n     (CLR_bar),
        .load      (load),
        .beat_idx  (beat_idx),
        .last_beat (last_beat),
        .busy      (bus.busy),
        .done      (bus.done)
    );

    // Shadow with the current beat dropped in; on the last beat this is the full operand.
    always_comb begin
        merged = shadow;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_idx == CNT_W'(b)) begin
                merged[b*BUS_WIDTH +: BUS_WIDTH] = bus.bus_input;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= merged;
        end
    end

`ifdef B_REG_SHIFT_EN
    logic             shift_req;
    logic [WIDTH-1:0] shifted;

    // Loads win over shifts, and shifting mid-assembly would corrupt a committed value.
    assign shift_req = bus.L_B_bar && bus.S_B && !bus.busy;
    assign shifted   = (bus.DIR == DIR_RIGHT) ? {bus.serial_in, operand[WIDTH-1:1]}
                                              : {operand[WIDTH-2:0], bus.serial_in};

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            operand <= '0;
        end else if (last_beat) begin
            operand <= merged;
        end else if (shift_req) begin
            operand <= shifted;
        end
    end
`else
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            operand <= '0;
        end else if (last_beat) begin
            operand <= merged;
        end
    end
`endif

    assign bus.add_sub_output = operand;

endmodule

// File: tb/tb_wide_operand_register.sv
// Self-checking bench for wide_operand_register: BEATS=2 and BEATS=1 instances,
// vector tables through an expectation queue plus a hand-written reset sequence.
module tb_wide_operand_register;

    typedef struct {
        bit          inst;      // 0: BEATS=2 instance, 1: BEATS=1 instance
        bit          load_n;
        bit          shift;
        bit          dir;
        bit          sin;
        logic [7:0]  data;
        logic [15:0] exp_out;
        bit          exp_busy;
        bit          exp_done;
        string       name;
    } vec_t;

    logic CLK = 1'b0;
    logic CLR_bar;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t sb[$];
    vec_t tab2[$];
    vec_t tab1[$];

    wide_operand_register_if #(.BUS_WIDTH(8), .BEATS(2)) bi2 ();
    wide_operand_register_if #(.BUS_WIDTH(8), .BEATS(1)) bi1 ();

    wide_operand_register #(.BUS_WIDTH(8), .BEATS(2)) dut2 (
        .CLK     (CLK),
        .CLR_bar (CLR_bar),
        .bus     (bi2.slave)
    );

    wide_operand_register #(.BUS_WIDTH(8), .BEATS(1)) dut1 (
        .CLK     (CLK),
        .CLR_bar (CLR_bar),
        .bus     (bi1.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(bit inst, bit load_n, bit shift, bit dir, bit sin,
                                logic [7:0] data, logic [15:0] exp_out,
                                bit exp_busy, bit exp_done, string name);
        vec_t v;
        v.inst = inst; v.load_n = load_n; v.shift = shift; v.dir = dir; v.sin = sin;
        v.data = data; v.exp_out = exp_out; v.exp_busy = exp_busy; v.exp_done = exp_done;
        v.name = name;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bi2.L_B_bar = 1'b1; bi2.bus_input = 8'h00;
        bi1.L_B_bar = 1'b1; bi1.bus_input = 8'h00;
`ifdef B_REG_SHIFT_EN
        bi2.S_B = 1'b0; bi2.DIR = 1'b0; bi2.serial_in = 1'b0;
        bi1.S_B = 1'b0; bi1.DIR = 1'b0; bi1.serial_in = 1'b0;
`endif
    endtask

    task automatic drive(vec_t v);
        set_idle();
        if (v.inst == 1'b0) begin
            bi2.L_B_bar   = v.load_n;
            bi2.bus_input = v.data;
`ifdef B_REG_SHIFT_EN
            bi2.S_B = v.shift; bi2.DIR = v.dir; bi2.serial_in = v.sin;
`endif
        end else begin
            bi1.L_B_bar   = v.load_n;
            bi1.bus_input = v.data;
`ifdef B_REG_SHIFT_EN
            bi1.S_B = v.shift; bi1.DIR = v.dir; bi1.serial_in = v.sin;
`endif
        end
        sb.push_back(v);
    endtask

    task automatic check_next();
        vec_t        e;
        logic [15:0] act_out;
        logic        act_busy;
        logic        act_done;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got 0 entries, expected 1");
            return;
        end
        e = sb.pop_front();
        if (e.inst == 1'b0) begin
            act_out = bi2.add_sub_output; act_busy = bi2.busy; act_done = bi2.done;
        end else begin
            act_out = {8'h00, bi1.add_sub_output}; act_busy = bi1.busy; act_done = bi1.done;
        end
        check({e.name, " out"},  act_out, e.exp_out);
        check({e.name, " busy"}, {15'h0, act_busy}, {15'h0, e.exp_busy});
        check({e.name, " done"}, {15'h0, act_done}, {15'h0, e.exp_done});
    endtask

    task automatic run_vec(vec_t v);
        @(negedge CLK);
        drive(v);
        @(posedge CLK);
        #1;
        check_next();
    endtask

    initial begin
        logic [15:0] last_out;

        // BEATS=2: load, done pulse, pause
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'hAC, 16'h0000, 1, 0, "load beat0"));
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'h5E, 16'h5EAC, 0, 1, "load beat1"));
        tab2.push_back(mk(0, 1, 0, 0, 0, 8'hFF, 16'h5EAC, 0, 0, "idle after commit"));
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'h34, 16'h5EAC, 1, 0, "pause beat0"));
        tab2.push_back(mk(0, 1, 0, 0, 0, 8'hEE, 16'h5EAC, 1, 0, "pause hold1"));
        tab2.push_back(mk(0, 1, 0, 0, 0, 8'hDD, 16'h5EAC, 1, 0, "pause hold2"));
        tab2.push_back(mk(0, 1, 0, 0, 0, 8'hCC, 16'h5EAC, 1, 0, "pause hold3"));
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'h12, 16'h1234, 0, 1, "pause beat1"));
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'hAC, 16'h1234, 1, 0, "reload beat0"));
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'h5E, 16'h5EAC, 0, 1, "reload beat1"));
        last_out = 16'h5EAC;
`ifdef B_REG_SHIFT_EN
        tab2.push_back(mk(0, 1, 1, 0, 1, 8'h00, 16'hBD59, 0, 0, "shift left"));
        tab2.push_back(mk(0, 1, 1, 1, 0, 8'h00, 16'h5EAC, 0, 0, "shift right"));
        tab2.push_back(mk(0, 0, 1, 0, 1, 8'h77, 16'h5EAC, 1, 0, "load beats shift"));
        tab2.push_back(mk(0, 1, 1, 0, 1, 8'h00, 16'h5EAC, 1, 0, "shift while busy"));
        tab2.push_back(mk(0, 0, 0, 0, 0, 8'h88, 16'h8877, 0, 1, "load after shift"));
        last_out = 16'h8877;
`endif

        // BEATS=1: every load commits directly
        tab1.push_back(mk(1, 0, 0, 0, 0, 8'hAC, 16'h00AC, 0, 1, "b1 load AC"));
        tab1.push_back(mk(1, 1, 0, 0, 0, 8'hF1, 16'h00AC, 0, 0, "b1 hold"));
        tab1.push_back(mk(1, 0, 0, 0, 0, 8'hF1, 16'h00F1, 0, 1, "b1 load F1"));
        tab1.push_back(mk(1, 1, 0, 0, 0, 8'h00, 16'h00F1, 0, 0, "b1 idle"));

        // Asynchronous reset with no clock edge in between
        CLR_bar = 1'b1;
        set_idle();
        #2 CLR_bar = 1'b0;
        #1;
        check("reset out2",  bi2.add_sub_output, 16'h0000);
        check("reset busy2", {15'h0, bi2.busy}, 16'h0000);
        check("reset done2", {15'h0, bi2.done}, 16'h0000);
        check("reset out1",  {8'h00, bi1.add_sub_output}, 16'h0000);
        check("reset busy1", {15'h0, bi1.busy}, 16'h0000);
        check("reset done1", {15'h0, bi1.done}, 16'h0000);
        repeat (2) @(negedge CLK);
        CLR_bar = 1'b1;

        foreach (tab2[i]) run_vec(tab2[i]);

        // Reset mid-operand discards the partial beat
        run_vec(mk(0, 0, 0, 0, 0, 8'hAC, last_out, 1, 0, "midreset beat0"));
        @(negedge CLK);
        set_idle();
        #2 CLR_bar = 1'b0;
        #1;
        check("midreset out",  bi2.add_sub_output, 16'h0000);
        check("midreset busy", {15'h0, bi2.busy}, 16'h0000);
        #1 CLR_bar = 1'b1;
        run_vec(mk(0, 0, 0, 0, 0, 8'h11, 16'h0000, 1, 0, "after reset beat0"));
        run_vec(mk(0, 0, 0, 0, 0, 8'h22, 16'h2211, 0, 1, "after reset beat1"));
        run_vec(mk(0, 1, 0, 0, 0, 8'h00, 16'h2211, 0, 0, "after reset idle"));

        foreach (tab1[i]) run_vec(tab1[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
